// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: control sequencer for a 16-point radix-2 FFT datapath.
// It drives sample-RAM write addresses during LOAD and butterfly operand addresses, twiddle
// indices and delayed write-back strobes during COMPUTE. During UNLOAD it streams result
// addresses under a ready handshake. It carries no data.
// Build option: define FFT_CTRL_BITREV_EN to bit-reverse the load addresses and read results
// in natural order. Otherwise samples load in natural order and results are read bit-reversed.
module fft_seq_ctrl #(
  parameter int unsigned N_LOG2   = 4,
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic                         out_ready,
  output logic [1:0]                   state,
  output logic                         busy,
  output logic                         load_we,
  output logic [N_LOG2-1:0]            load_addr,
  output logic                         bfly_go,
  output logic [N_LOG2-1:0]            addr_a,
  output logic [N_LOG2-1:0]            addr_b,
  output logic [N_LOG2-2:0]            tw_idx,
  output logic [$clog2(N_LOG2)-1:0]    stage,
  output logic                         wb_en,
  output logic [N_LOG2-1:0]            wb_addr_a,
  output logic [N_LOG2-1:0]            wb_addr_b,
  output logic                         out_valid,
  output logic [N_LOG2-1:0]            out_addr,
  output logic                         out_last,
  output logic                         done
);

  localparam int unsigned Half   = (1 << N_LOG2) / 2;
  localparam int unsigned StageW = $clog2(N_LOG2);
  localparam int unsigned TwW    = N_LOG2 - 1;
  localparam int unsigned PosW   = $clog2(Half + BFLY_LAT);

  localparam logic [N_LOG2-1:0] CntLast   = '1;
  localparam logic [PosW-1:0]   IssueLast = PosW'(Half - 1);
  localparam logic [PosW-1:0]   PosLast   = PosW'(Half + BFLY_LAT - 1);
  localparam logic [StageW-1:0] StageLast = StageW'(N_LOG2 - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StUnload  = 2'd3
  } state_e;

  state_e              state_q;
  logic [N_LOG2-1:0]   cnt_q;     // sample count in LOAD, result count in UNLOAD
  logic [PosW-1:0]     pos_q;     // cycle within stage: issues first, then drain
  logic [StageW-1:0]   stage_q;
  logic                bfly_go_q;
  logic [N_LOG2-1:0]   addr_a_q;
  logic [N_LOG2-1:0]   addr_b_q;
  logic [TwW-1:0]      tw_idx_q;
  logic                done_q;

  logic [StageW-1:0]   iss_stage;
  logic [PosW-1:0]     iss_k;
  logic [N_LOG2-1:0]   iss_a;
  logic [N_LOG2-1:0]   iss_b;
  logic [TwW-1:0]      iss_tw;

  logic [BFLY_LAT-1:0] wb_go_q;
  logic [N_LOG2-1:0]   wb_a_q [BFLY_LAT];
  logic [N_LOG2-1:0]   wb_b_q [BFLY_LAT];

  function automatic logic [N_LOG2-1:0] calc_addr_a(input int s, input int k);
    int half;
    half = 1 << s;
    return N_LOG2'(((k >> s) << (s + 1)) | (k & (half - 1)));
  endfunction

  function automatic logic [TwW-1:0] calc_tw(input int s, input int k);
    int half;
    half = 1 << s;
    return TwW'((k & (half - 1)) << (N_LOG2 - 1 - s));
  endfunction

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  // Coordinates and addresses of the butterfly that would issue in the next cycle.
  always_comb begin
    iss_stage = stage_q;
    iss_k     = pos_q + 1'b1;
    if (state_q != StCompute) begin
      iss_stage = '0;
      iss_k     = '0;
    end else if (pos_q == PosLast) begin
      iss_stage = stage_q + 1'b1;
      iss_k     = '0;
    end
    iss_a  = calc_addr_a(int'(iss_stage), int'(iss_k));
    iss_b  = iss_a + (N_LOG2'(1) << iss_stage);
    iss_tw = calc_tw(int'(iss_stage), int'(iss_k));
  end

  // Main FSM with registered issue strobe, operand addresses and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pos_q     <= '0;
      stage_q   <= '0;
      bfly_go_q <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      tw_idx_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bfly_go_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            cnt_q   <= '0;
          end
        end
        StLoad: begin
          if (sample_valid) begin
            // Wraps to zero on the last sample, ready for UNLOAD later.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q   <= StCompute;
              stage_q   <= '0;
              pos_q     <= '0;
              bfly_go_q <= 1'b1;
              addr_a_q  <= iss_a;
              addr_b_q  <= iss_b;
              tw_idx_q  <= iss_tw;
            end
          end
        end
        StCompute: begin
          if (pos_q == PosLast) begin
            pos_q <= '0;
            if (stage_q == StageLast) begin
              state_q <= StUnload;
              stage_q <= '0;
            end else begin
              stage_q   <= stage_q + 1'b1;
              bfly_go_q <= 1'b1;
              addr_a_q  <= iss_a;
              addr_b_q  <= iss_b;
              tw_idx_q  <= iss_tw;
            end
          end else begin
            pos_q <= pos_q + 1'b1;
            // Past the last issue the stage drains so write-backs land before the next stage.
            if (pos_q < IssueLast) begin
              bfly_go_q <= 1'b1;
              addr_a_q  <= iss_a;
              addr_b_q  <= iss_b;
              tw_idx_q  <= iss_tw;
            end
          end
        end
        StUnload: begin
          if (out_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write-back delay line: a plain BFLY_LAT-deep shift of the issue strobe and addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_go_q <= '0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        wb_a_q[i] <= '0;
        wb_b_q[i] <= '0;
      end
    end else begin
      wb_go_q[0] <= bfly_go_q;
      wb_a_q[0]  <= addr_a_q;
      wb_b_q[0]  <= addr_b_q;
      for (int i = 1; i < BFLY_LAT; i++) begin
        wb_go_q[i] <= wb_go_q[i-1];
        wb_a_q[i]  <= wb_a_q[i-1];
        wb_b_q[i]  <= wb_b_q[i-1];
      end
    end
  end

  assign state     = state_q;
  assign busy      = (state_q != StIdle);
  assign load_we   = (state_q == StLoad) && sample_valid;
  assign bfly_go   = bfly_go_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign stage     = stage_q;
  assign wb_en     = wb_go_q[BFLY_LAT-1];
  assign wb_addr_a = wb_a_q[BFLY_LAT-1];
  assign wb_addr_b = wb_b_q[BFLY_LAT-1];
  assign out_valid = (state_q == StUnload);
  assign out_last  = (state_q == StUnload) && (cnt_q == CntLast);
  assign done      = done_q;

`ifdef FFT_CTRL_BITREV_EN
  assign load_addr = bitrev(cnt_q);
  assign out_addr  = cnt_q;
`else
  assign load_addr = cnt_q;
  assign out_addr  = bitrev(cnt_q);
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed self-checking bench for fft_seq_ctrl (default parameters).
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] state;
  logic       busy, load_we, bfly_go, wb_en, out_valid, out_last, done;
  logic [3:0] load_addr, addr_a, addr_b, wb_addr_a, wb_addr_b, out_addr;
  logic [2:0] tw_idx;
  logic [1:0] stage;

  int checks = 0;
  int failures = 0;

  // Hand-computed butterfly vectors at selected COMPUTE cycles.
  int spot_c[5]  = '{0, 7, 11, 25, 37};
  int spot_a[5]  = '{0, 14, 1, 9, 7};
  int spot_b[5]  = '{1, 15, 3, 13, 15};
  int spot_tw[5] = '{0, 0, 4, 2, 7};

  fft_seq_ctrl #(.N_LOG2(4), .BFLY_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .out_ready(out_ready),
    .state(state), .busy(busy), .load_we(load_we), .load_addr(load_addr), .bfly_go(bfly_go),
    .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx), .stage(stage), .wb_en(wb_en),
    .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b), .out_valid(out_valid), .out_addr(out_addr),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [3:0] exp_load(input int i);
    logic [3:0] v;
    v = 4'(i);
`ifdef FFT_CTRL_BITREV_EN
    return rev4(v);
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] exp_out(input int j);
    logic [3:0] v;
    v = 4'(j);
`ifdef FFT_CTRL_BITREV_EN
    return v;
`else
    return rev4(v);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, bfly_go, wb_en, out_valid, out_last, done, load_we} !== 7'b0 || state !== 2'd0) begin
      failures++;
      $display("FAIL reset_strobes state=%0d strobes=%b exp state=0 strobes=0000000", state,
               {busy, bfly_go, wb_en, out_valid, out_last, done, load_we});
    end
    checks++;
    if ({addr_a, addr_b, tw_idx, stage, wb_addr_a, wb_addr_b, load_addr, out_addr} !== '0) begin
      failures++;
      $display("FAIL reset_addrs a=%0d b=%0d tw=%0d stage=%0d la=%0d oa=%0d exp all 0",
               addr_a, addr_b, tw_idx, stage, load_addr, out_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0; sample_valid = 1'b1; #1;
      checks++;
      if (load_we !== 1'b1 || load_addr !== exp_load(i)) begin
        failures++;
        $display("FAIL pre_reset_load i=%0d we=%b addr=%0d exp we=1 addr=%0d", i, load_we,
                 load_addr, exp_load(i));
      end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state !== 2'd0 || {busy, bfly_go, wb_en, out_valid, done, load_we} !== 6'b0) begin
      failures++;
      $display("FAIL mid_load_reset state=%0d busy=%b we=%b exp state=0 all strobes 0", state,
               busy, load_we);
    end
    @(negedge clk); rst = 1'b0; sample_valid = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || load_addr !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_idle state=%0d addr=%0d exp state=0 addr=0", state, load_addr);
    end
  endtask

  task automatic test_load(input bit gaps);
    int writes;
    writes = 0;
    @(negedge clk); start = 1'b1; sample_valid = 1'b1; #1;
    checks++;
    if (state !== 2'd0 || load_we !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL load_start_cycle state=%0d we=%b done=%b exp state=0 we=0 done=0", state,
               load_we, done);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); start = 1'b0; sample_valid = 1'b1; #1;
      if (load_we) writes++;
      checks++;
      if (state !== 2'd1 || load_we !== 1'b1 || load_addr !== exp_load(i)) begin
        failures++;
        $display("FAIL load_write i=%0d state=%0d we=%b addr=%0d exp state=1 we=1 addr=%0d", i,
                 state, load_we, load_addr, exp_load(i));
      end
      if (gaps && i < 15) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk); sample_valid = 1'b0; #1;
          if (load_we) writes++;
          checks++;
          if (state !== 2'd1 || load_we !== 1'b0 || load_addr !== exp_load(i + 1)) begin
            failures++;
            $display("FAIL load_gap i=%0d state=%0d we=%b addr=%0d exp state=1 we=0 addr=%0d",
                     i, state, load_we, load_addr, exp_load(i + 1));
          end
        end
      end
    end
    checks++;
    if (writes != 16) begin
      failures++;
      $display("FAIL load_write_count got=%0d exp=16", writes);
    end
  endtask

  task automatic test_compute();
    logic [3:0] a_hist [40];
    logic [3:0] b_hist [40];
    bit         go_hist [40];
    int s, p, half, a, b, tw, wbs;
    bit go, exp_wb;
    wbs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      start = (c >= 5 && c < 8) || c == 25;
      #1;
      s = c / 10; p = c % 10; go = (p < 8);
      half = 1 << s;
      a = ((p >> s) << (s + 1)) | (p & (half - 1));
      b = a + half;
      tw = ((p & (half - 1)) << (3 - s)) & 7;
      go_hist[c] = go; a_hist[c] = 4'(a); b_hist[c] = 4'(b);
      checks++;
      if (state !== 2'd2 || stage !== 2'(s) || bfly_go !== go) begin
        failures++;
        $display("FAIL compute_ctrl c=%0d state=%0d stage=%0d go=%b exp state=2 stage=%0d go=%b",
                 c, state, stage, bfly_go, s, go);
      end
      if (go) begin
        checks++;
        if (addr_a !== 4'(a) || addr_b !== 4'(b) || tw_idx !== 3'(tw)) begin
          failures++;
          $display("FAIL compute_addr c=%0d a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", c,
                   addr_a, addr_b, tw_idx, a, b, tw);
        end
      end
      for (int t = 0; t < 5; t++) begin
        if (spot_c[t] == c) begin
          checks++;
          if (addr_a !== 4'(spot_a[t]) || addr_b !== 4'(spot_b[t]) ||
              tw_idx !== 3'(spot_tw[t])) begin
            failures++;
            $display("FAIL compute_spot c=%0d a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d", c,
                     addr_a, addr_b, tw_idx, spot_a[t], spot_b[t], spot_tw[t]);
          end
        end
      end
      exp_wb = (c >= 2) ? go_hist[c-2] : 1'b0;
      if (wb_en) wbs++;
      checks++;
      if (wb_en !== exp_wb) begin
        failures++;
        $display("FAIL wb_timing c=%0d wb_en=%b exp=%b", c, wb_en, exp_wb);
      end
      if (exp_wb) begin
        checks++;
        if (wb_addr_a !== a_hist[c-2] || wb_addr_b !== b_hist[c-2]) begin
          failures++;
          $display("FAIL wb_addr c=%0d a=%0d b=%0d exp a=%0d b=%0d", c, wb_addr_a, wb_addr_b,
                   a_hist[c-2], b_hist[c-2]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (wbs != 32) begin
      failures++;
      $display("FAIL wb_count got=%0d exp=32", wbs);
    end
  endtask

  task automatic test_unload(input bit toggle);
    int j, cyc, lasts;
    j = 0; cyc = 0; lasts = 0;
    while (j < 16 && cyc < 80) begin
      @(negedge clk);
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start = (j < 8);
      #1;
      checks++;
      if (state !== 2'd3 || out_valid !== 1'b1 || busy !== 1'b1 || out_addr !== exp_out(j) ||
          out_last !== (j == 15) || done !== 1'b0) begin
        failures++;
        $display("FAIL unload j=%0d state=%0d valid=%b addr=%0d last=%b exp state=3 valid=1 addr=%0d last=%b",
                 j, state, out_valid, out_addr, out_last, exp_out(j), (j == 15));
      end
      if (out_last && out_ready) lasts++;
      if (out_ready) j++;
      cyc++;
    end
    checks++;
    if (j != 16) begin
      failures++;
      $display("FAIL unload_timeout accepted=%0d exp=16", j);
    end
    @(negedge clk); out_ready = 1'b0; start = 1'b0; #1;
    checks++;
    if (state !== 2'd0 || done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL unload_done state=%0d done=%b valid=%b exp state=0 done=1 valid=0", state,
               done, out_valid);
    end
    checks++;
    if (lasts != 1) begin
      failures++;
      $display("FAIL last_count got=%0d exp=1", lasts);
    end
  endtask

  task automatic test_back_to_back();
    test_load(1'b1);
    test_compute();
    test_unload(1'b0);
  endtask

  initial begin
    test_reset();
    test_load(1'b0);
    test_compute();
    test_unload(1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
Sequencer for the 16-point radix-2 FFT datapath: accepts a start pulse and a stream of serial samples, generates sample-RAM write addresses, then issues butterfly operand addresses, twiddle indices and write-back strobes stage by stage. It finishes by streaming result addresses out under a ready handshake. It sits between the sample source and the butterfly/twiddle/RAM datapath, which holds all arithmetic; this block carries no data.

Parameters:
N_LOG2, 4, log2 of FFT length (N = 16)
BFLY_LAT, 2, butterfly pipeline latency in cycles from issue to write-back (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a transform; honoured only in IDLE
sample_valid  in  1  a sample is present on the datapath input this cycle
out_ready  in  1  downstream accepts the current result
state  out  2  0 IDLE, 1 LOAD, 2 COMPUTE, 3 UNLOAD
busy  out  1  state != IDLE
load_we  out  1  write the current sample to RAM (comb: LOAD & sample_valid)
load_addr  out  N_LOG2  RAM address for the current sample
bfly_go  out  1  butterfly issue strobe (registered)
addr_a  out  N_LOG2  top operand address (registered)
addr_b  out  N_LOG2  bottom operand address (registered)
tw_idx  out  N_LOG2-1  twiddle ROM index (registered)
stage  out  N_LOG2-bit? no: ceil(log2 N_LOG2) = 2  current stage 0..N_LOG2-1
wb_en  out  1  write-back strobe, bfly_go delayed BFLY_LAT cycles
wb_addr_a  out  N_LOG2  addr_a delayed BFLY_LAT cycles
wb_addr_b  out  N_LOG2  addr_b delayed BFLY_LAT cycles
out_valid  out  1  result address valid
out_addr  out  N_LOG2  RAM address of the current result
out_last  out  1  out_valid on the final (Nth) result
done  out  1  one-cycle pulse on the UNLOAD->IDLE transition

Behaviour:
- Reset: state=IDLE and all counters 0. bfly_go, wb_en, out_valid, out_last, done, busy = 0; all address, index and stage outputs = 0. The wb delay line is flushed. Reset mid-operation aborts immediately with no further strobes.
- IDLE: start=1 -> LOAD next cycle. Samples presented during the start cycle are ignored.
- LOAD: each cycle with sample_valid=1, load_we=1 and the sample counter increments; there is no write on gaps. When the counter reaches N-1 with valid, go to COMPUTE next cycle and clear the counter. start is ignored outside IDLE.
- COMPUTE: for stage s = 0..N_LOG2-1, issue k = 0..N/2-1, one per cycle, with bfly_go=1. Address generation per issue:
  - half = 1<<s
  - addr_a = ((k>>s)<<(s+1)) | (k & (half-1))
  - addr_b = addr_a + half
  - tw_idx = (k & (half-1)) << (N_LOG2-1-s)
- After the last issue of a stage, bfly_go=0 for BFLY_LAT drain cycles so all write-backs land before the next stage reads; then advance to the next stage.
- After the final stage's drain, go to UNLOAD. With defaults, COMPUTE lasts 4*(8+2) = 40 cycles.
- wb_en/wb_addr_* is a pure BFLY_LAT-deep shift of bfly_go/addr_*. The last wb_en occurs in the final drain cycle, before UNLOAD is entered.
- UNLOAD: out_valid=1 continuously. out_addr advances only on out_valid & out_ready and holds otherwise. out_last=1 while the counter = N-1.
- On acceptance of the last result: go to IDLE with done=1 for that one cycle and out_valid=0.
- All arithmetic is modulo 2^N_LOG2, and counters wrap naturally; no saturation.

Optional Feature:
FFT_CTRL_BITREV_EN: defined -> load_addr = bit-reverse(sample count) and out_addr = natural count (input reordered, output in order). Undefined -> load_addr = natural count and out_addr = bit-reverse(count) (output reordered). Butterfly addressing is identical in both builds.

Test Plan:
1. rst=1 for 2 cycles mid-LOAD, after 5 samples -> state=0, all strobes 0; a following start plus 16 samples loads cleanly.
2. start, then 16 consecutive valid samples (10,18,19,12,3,0,6,15,20,16,7,0,2,11,19,19) -> 16 load_we pulses. With BITREV_EN, load_addr = 0,8,4,12,2,...,15; otherwise 0..15. COMPUTE is entered after the 16th sample.
3. sample_valid gaps (valid 1,0,0,1,... for 16 valid samples) -> exactly 16 writes, no address skipped, and no COMPUTE until the 16th valid sample.
4. COMPUTE trace with defaults -> stage 0 pairs (0,1),(2,3)...(14,15) with tw 0; stage 1 k=1 gives (1,3) tw 4; stage 3 k=7 gives (7,15) tw 7. wb_en pulses = 32, each exactly 2 cycles after its issue, and no issue occurs while a prior-stage write-back is pending.
5. UNLOAD with out_ready toggling 1,0,1,0 -> out_addr advances only on ready cycles. out_last and done occur exactly once each, and state returns to 0 after the 16th acceptance.
6. start asserted during COMPUTE and UNLOAD -> ignored. Back-to-back: start in the cycle after done -> a new LOAD begins normally.
